mic_capture: RTL and testbench
==============================

# mic_capture

Front-end sample capture stage sitting directly upstream of the delay line. It drives a serial ADC (chip-select, serial clock, serial data in), deserialises one WIDTH-bit sample per sample period, and presents it on `sample` with a one-cycle `wr` strobe that connects straight to the delay line's write-enable and data inputs. Conversion rate and serial clock rate are fixed by parameters.

## Interface
- `WIDTH`, 8, sample width in bits; equals the delay line's WIDTH.
- `SCLK_DIV`, 4, clk cycles per half-period of `adc_sclk` (≥1).
- `SAMPLE_PERIOD`, 128, clk cycles between conversion starts; must be ≥ 2·SCLK_DIV·WIDTH + SCLK_DIV + 2.

- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  enables conversions; sampled at each period boundary.
- `adc_sdata`  in  1  serial data from ADC, MSB first.
- `adc_cs_n`  out  1  ADC chip select, active low, registered.
- `adc_sclk`  out  1  ADC serial clock, registered.
- `sample`  out  WIDTH  last completed sample, held until next completion.
- `wr`  out  1  one-cycle pulse when `sample` updates.

## Operation
- Free-running period counter 0..SAMPLE_PERIOD-1, runs while out of reset regardless of `en`; wraps to 0.
- FSM states: IDLE, SETUP, SHIFT, DONE.
- IDLE: `adc_cs_n`=1, `adc_sclk`=0. At period count 0 with `en`=1 → SETUP; with `en`=0 stay IDLE.
- SETUP: `adc_cs_n`=0 for SCLK_DIV cycles (data setup), `adc_sclk`=0 → SHIFT.
- SHIFT: `adc_sclk` toggles every SCLK_DIV cycles, starting low; WIDTH rising edges. `adc_sdata` sampled in the clk cycle the registered `adc_sclk` goes 0→1, shifted into LSB of a WIDTH-bit shift register (first bit ends as MSB). Bit counter 0..WIDTH-1. After the WIDTH-th high half-period, `adc_sclk` returns 0 → DONE.
- DONE (one cycle): `adc_cs_n`←1, `sample`←result, `wr`←1 → IDLE.
- `en` deassert mid-conversion: current conversion completes and writes; no new start until `en`=1 at a later count 0.
- Period boundary arriving while not IDLE cannot occur under the SAMPLE_PERIOD constraint; if it does, the start is skipped (no restart mid-frame).
- Reset (any time, including mid-frame): FSM→IDLE, counters→0, shift register→0; outputs `adc_cs_n`=1, `adc_sclk`=0, `sample`=0, `wr`=0. Partial frame discarded, no `wr`.

## Timing
- Count 0 (en=1) → `adc_cs_n` low at next edge (1 cycle).
- First `adc_sclk` rise SCLK_DIV cycles after `adc_cs_n` falls; sclk period 2·SCLK_DIV.
- `wr` high exactly one cycle, same cycle `sample` shows new value; `adc_cs_n` high from that cycle.
- Frame length cs_n-low to `wr`: SCLK_DIV + 2·SCLK_DIV·WIDTH + 1 cycles (defaults: 69).
- One `wr` per SAMPLE_PERIOD maximum; `wr` never asserts while `adc_cs_n`=0.

## Configuration
- `MIC_CAPTURE_AVG_EN` defined: `sample` = (new + previous raw) >> 1, computed at WIDTH+1 bits then truncated (floor); previous raw register reset to 0, so first sample after reset is new>>1. Latency unchanged.
- Undefined: `sample` = raw deserialised value; no previous-sample register.

## Test plan
- Reset: hold `rst`=1, drive `adc_sdata` toggling → `adc_cs_n`=1, `adc_sclk`=0, `sample`=0, `wr`=0 throughout.
- Single capture: `en`=1, ADC model returns 0xA5 MSB first → after 69 cycles from cs_n fall, `sample`=0xA5, `wr` one-cycle pulse, 8 sclk rises counted.
- Back-to-back: model returns 0x00, 0xFF, 0x3C on successive frames → `wr` pulses spaced exactly 128 cycles, samples in order.
- `en` drop: deassert `en` during bit 3 of 0x5A frame → frame completes with 0x5A, no further cs_n activity until `en`=1 and next count 0.
- Mid-frame reset: assert `rst` at bit 5 → outputs to reset values immediately (async), no `wr`; after release next frame captures correctly.
- With `MIC_CAPTURE_AVG_EN`: raw 0x80 then 0x41 → `sample` 0x40 then 0x60.

Source files
------------

// File: rtl/mic_capture.sv
`timescale 1ns/1ps
// mic_capture: serial ADC front end. Drives chip-select and serial clock,
// deserialises one WIDTH-bit word per sample period (MSB first) and presents
// it on sample with a one-cycle wr strobe for the downstream delay line.
// Optional feature macro: MIC_CAPTURE_AVG_EN (two-sample running average).
module mic_capture #(
  parameter int WIDTH         = 8,
  parameter int SCLK_DIV      = 4,
  parameter int SAMPLE_PERIOD = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             adc_sdata,
  output logic             adc_cs_n,
  output logic             adc_sclk,
  output logic [WIDTH-1:0] sample,
  output logic             wr
);

  localparam int CNT_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int DIV_W = $clog2(SCLK_DIV + 1);
  localparam int BIT_W = $clog2(WIDTH + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_PERIOD - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, DONE} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_div;
  logic [BIT_W-1:0] r_bit;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] w_result;
  logic             w_div_end;
  logic             w_boundary;

  assign w_div_end  = (r_div == DIV_LAST);
  assign w_boundary = (r_cnt == '0);

`ifdef MIC_CAPTURE_AVG_EN
  logic [WIDTH-1:0] r_prev;

  // Average with the previous raw word; the sum is formed one bit wider so
  // the carry survives before the floor division by two.
  assign w_result = WIDTH'(({1'b0, r_shift} + {1'b0, r_prev}) >> 1);

  // Remember the raw word of each completed frame for the next average.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev <= '0;
    end else if (r_state == DONE) begin
      r_prev <= r_shift;
    end
  end
`else
  assign w_result = r_shift;
`endif

  // Free-running period counter, independent of en.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Frame sequencer: chip-select, serial clock, shift register and output strobe.
  // A boundary seen outside IDLE is simply ignored, so a frame is never restarted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_div    <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      adc_cs_n <= 1'b1;
      adc_sclk <= 1'b0;
      sample   <= '0;
      wr       <= 1'b0;
    end else begin
      wr <= 1'b0;
      case (r_state)
        IDLE: begin
          adc_cs_n <= 1'b1;
          adc_sclk <= 1'b0;
          if (w_boundary && en) begin
            adc_cs_n <= 1'b0;
            r_div    <= '0;
            r_state  <= SETUP;
          end
        end
        // Hold sclk low with cs_n asserted; the first rise also captures MSB.
        SETUP: begin
          if (w_div_end) begin
            r_div    <= '0;
            r_bit    <= '0;
            adc_sclk <= 1'b1;
            r_shift  <= {r_shift[WIDTH-2:0], adc_sdata};
            r_state  <= SHIFT;
          end else begin
            r_div <= r_div + DIV_W'(1);
          end
        end
        // Each half period lasts SCLK_DIV cycles; data is taken on each rise.
        // After the last high half a final low half completes the sclk period.
        SHIFT: begin
          if (w_div_end) begin
            r_div <= '0;
            if (adc_sclk) begin
              adc_sclk <= 1'b0;
            end else if (r_bit == BIT_LAST) begin
              r_state <= DONE;
            end else begin
              adc_sclk <= 1'b1;
              r_bit    <= r_bit + BIT_W'(1);
              r_shift  <= {r_shift[WIDTH-2:0], adc_sdata};
            end
          end else begin
            r_div <= r_div + DIV_W'(1);
          end
        end
        DONE: begin
          adc_cs_n <= 1'b1;
          sample   <= w_result;
          wr       <= 1'b1;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mic_capture.sv
`timescale 1ns/1ps
// tb_mic_capture: randomized scoreboard bench. A behavioural ADC serves words
// from a queue and records each served word; a monitor pops and checks
// every wr strobe plus frame timing and start alignment.
module tb_mic_capture;

  localparam int W     = 8;
  localparam int D     = 4;
  localparam int P     = 128;
  localparam int FRAME = D + 2 * D * W + 1;
`ifdef MIC_CAPTURE_AVG_EN
  localparam bit AVG = 1'b1;
`else
  localparam bit AVG = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         adc_sdata = 1'b0;
  logic         adc_cs_n;
  logic         adc_sclk;
  logic [W-1:0] sample;
  logic         wr;

  mic_capture #(.WIDTH(W), .SCLK_DIV(D), .SAMPLE_PERIOD(P)) dut (
    .clk(clk), .rst(rst), .en(en), .adc_sdata(adc_sdata),
    .adc_cs_n(adc_cs_n), .adc_sclk(adc_sclk), .sample(sample), .wr(wr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  int unsigned word_q[$];
  int unsigned exp_q[$];

  // Behavioural ADC: MSB valid once cs_n falls, next bit after each sclk fall.
  logic [W-1:0] adc_word;
  int           adc_bit = 0;
  bit           adc_active = 1'b0;
  logic         adc_prev_sclk = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      if (adc_active) void'(exp_q.pop_back());
      adc_active    = 1'b0;
      adc_prev_sclk = 1'b0;
      adc_sdata     = ~adc_sdata;
    end else begin
      if (!adc_active && !adc_cs_n) begin
        if (word_q.size() != 0) adc_word = W'(word_q.pop_front());
        else                    adc_word = W'($urandom);
        exp_q.push_back(int'(adc_word));
        adc_active = 1'b1;
        adc_bit    = 0;
        adc_sdata  = adc_word[W-1];
      end else if (adc_active && adc_cs_n) begin
        adc_active = 1'b0;
      end else if (adc_active && adc_prev_sclk && !adc_sclk) begin
        adc_bit++;
        if (adc_bit < W) adc_sdata = adc_word[W-1-adc_bit];
        else             adc_sdata = 1'b0;
      end
      adc_prev_sclk = adc_sclk;
    end
  end

  int   cyc;
  logic en_s;
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end
  always @(posedge clk) en_s <= en;

  // Monitor / scoreboard.
  int   n_wr = 0;
  int   rises = 0;
  int   fall_cyc = 0;
  int   last_wr = 0;
  int   prev_raw = 0;
  bit   have_last = 1'b0;
  bit   wr_prev = 1'b0;
  logic mon_cs = 1'b1;
  logic mon_sclk = 1'b0;

  always @(negedge clk) begin
    bit got_fall;
    bit at_bound;
    bit exp_fall;
    int raw;
    int expv;
    if (rst) begin
      rises     = 0;
      prev_raw  = 0;
      have_last = 1'b0;
      wr_prev   = 1'b0;
      mon_cs    = 1'b1;
      mon_sclk  = 1'b0;
    end else begin
      got_fall = mon_cs && !adc_cs_n;
      at_bound = (cyc % P) == 1;
      exp_fall = at_bound && en_s && mon_cs;
      if (got_fall || at_bound)
        chk(got_fall == exp_fall, "start_at_boundary", int'(got_fall), int'(exp_fall));
      if (got_fall) begin
        fall_cyc = cyc;
        rises    = 0;
      end
      if (!mon_sclk && adc_sclk) begin
        rises++;
        chk(!adc_cs_n, "sclk_rise_with_cs_low", int'(adc_cs_n), 0);
      end
      if (wr_prev) chk(!wr, "wr_one_cycle", int'(wr), 0);
      if (wr) begin
        n_wr++;
        chk(adc_cs_n === 1'b1, "wr_with_cs_high", int'(adc_cs_n), 1);
        chk(cyc - fall_cyc == FRAME, "frame_length", cyc - fall_cyc, FRAME);
        chk(rises == W, "sclk_rises", rises, W);
        if (have_last)
          chk((cyc - last_wr) % P == 0, "wr_spacing", cyc - last_wr,
              P * ((cyc - last_wr + P / 2) / P));
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_wr", int'(sample), 0);
        end else begin
          raw      = int'(exp_q.pop_front());
          expv     = AVG ? ((raw + prev_raw) >> 1) : raw;
          prev_raw = raw;
          $display("wr %0d: raw=0x%02h sample=0x%02h expected=0x%02h", n_wr, raw, sample, expv);
          chk(int'(sample) == expv, "sample_value", int'(sample), expv);
        end
        last_wr   = cyc;
        have_last = 1'b1;
        rises     = 0;
      end
      wr_prev  = wr;
      mon_cs   = adc_cs_n;
      mon_sclk = adc_sclk;
    end
  end

  task automatic wait_wr(input int count, input string name);
    int target;
    int k;
    target = n_wr + count;
    k = 0;
    while (n_wr < target && k < (count + 2) * P) begin
      @(negedge clk);
      k++;
    end
    chk(n_wr >= target, name, n_wr, target);
  endtask

  task automatic wait_rises(input int r, input string name);
    int k;
    k = 0;
    while (!(rises >= r && !adc_cs_n) && k < 4 * P) begin
      @(negedge clk);
      k++;
    end
    chk(rises >= r && !adc_cs_n, name, rises, r);
  endtask

  task automatic check_reset_outputs(input string name);
    chk(adc_cs_n === 1'b1 && adc_sclk === 1'b0 && sample === '0 && wr === 1'b0,
        name, int'({sample, adc_cs_n, adc_sclk, wr}), 4);
  endtask

  initial begin
    int low_cycles;
    int wr_before;
    rst = 1'b1;
    en  = 1'b0;

    // Held in reset with toggling serial data.
    repeat (10) begin
      @(negedge clk);
      #1;
      check_reset_outputs("reset_outputs");
    end

    // Single capture of 0xA5.
    word_q.push_back(32'hA5);
    @(negedge clk);
    #2;
    rst = 1'b0;
    en  = 1'b1;
    wait_wr(1, "single_capture_wr");

    // Back-to-back frames.
    word_q.push_back(32'h00);
    word_q.push_back(32'hFF);
    word_q.push_back(32'h3C);
    wait_wr(3, "back_to_back_wr");

    // Random words.
    repeat (4) word_q.push_back($urandom_range(0, 255));
    wait_wr(4, "random_wr_a");

    // Drop en during bit 3; frame still completes, then no activity.
    word_q.push_back(32'h5A);
    wait_rises(3, "reach_bit3");
    en = 1'b0;
    wait_wr(1, "en_drop_frame_wr");
    wr_before  = n_wr;
    low_cycles = 0;
    repeat (3 * P) begin
      @(negedge clk);
      if (!adc_cs_n) low_cycles++;
    end
    chk(low_cycles == 0, "cs_idle_while_disabled", low_cycles, 0);
    chk(n_wr == wr_before, "no_wr_while_disabled", n_wr, wr_before);
    repeat (37) @(negedge clk);
    word_q.push_back($urandom_range(0, 255));
    en = 1'b1;
    wait_wr(1, "reenable_wr");

    // Reset in the middle of a frame; that word must never appear.
    word_q.push_back(32'h77);
    wait_rises(5, "reach_bit5");
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("midframe_reset_outputs");
    word_q.push_back(32'h80);
    word_q.push_back(32'h41);
    repeat (3) begin
      @(negedge clk);
      #1;
      check_reset_outputs("midframe_reset_hold");
    end
    @(negedge clk);
    #2;
    rst = 1'b0;
    wait_wr(2, "post_reset_wr");

    // More random words.
    repeat (6) word_q.push_back($urandom_range(0, 255));
    wait_wr(6, "random_wr_b");

    repeat (5) @(negedge clk);
    chk(exp_q.size() == 0, "scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
